isq_issue_select: RTL and testbench
===================================

// Module: isq_issue_select
// PURPOSE
//  Consumer side of the issue-queue entry array: scans per-entry ready_to_dequeue, picks one winner
//  per cycle, returns the entry's clear_entry pulse and drives one issued op to a function unit.
//  Sits between the ISQ entry array and FU dispatch; valid/ready handshake toward the FU.
// PARAMETERS
//  DEPTH       8                  number of ISQ entries scanned
//  DATA_WIDTH  `ISQ_DATA_WIDTH    payload width per entry
//  INDEX_WIDTH `ISQ_INDEX_WIDTH   index width per entry
// PORTS
//  clock        in   1                      clock
//  reset_n      in   1                      reset, asynchronous, active-low
//  flush        in   1                      kill held op; block selection this cycle
//  alloc_vec    in   DEPTH                  per-entry wr_en pulse (entry being written)
//  ready_vec    in   DEPTH                  per-entry ready_to_dequeue_out
//  entry_data   in   DEPTH*DATA_WIDTH       per-entry data_out, entry i at [i*DATA_WIDTH +: DATA_WIDTH]
//  entry_index  in   DEPTH*INDEX_WIDTH      per-entry index_out, same packing
//  clear_vec    out  DEPTH                  one-hot clear_entry to the selected entry, same cycle
//  issue_valid  out  1                      issued op held
//  issue_ready  in   1                      FU accepts op
//  issue_data   out  DATA_WIDTH             issued payload
//  issue_index  out  INDEX_WIDTH            issued index
//  issue_slot   out  $clog2(DEPTH)          entry number the op came from
// BEHAVIOUR
//  - Reset: issue_valid=0, issue_data=0, issue_index=0, issue_slot=0, age state all 0; clear_vec=0 (comb).
//  - Output register (1-deep): can_load = !issue_valid || issue_ready. Select only when can_load && !flush.
//  - Selection comb: winner = selected ready entry; clear_vec = onehot(winner) when select && |ready_vec.
//  - Same edge as clear: issue_valid<=1, data/index/slot <= winner's. Latency ready->issue_valid = 1 cycle.
//  - No ready entry and issue_ready (or empty): issue_valid<=0; data/index/slot hold.
//  - issue_valid && !issue_ready: hold all outputs stable, clear_vec=0 (no selection, no entry lost).
//  - Back-to-back: with issue_ready held 1 and N ready entries, one issue per cycle, N cycles.
//  - flush: clear_vec=0 that cycle; issue_valid<=0 next edge; age state untouched (entries cleared upstream).
//  - alloc_vec[i] and clear_vec[i] never both 1 (allocation only to invalid entry); no check required.
//  - Entry just allocated is not ready the same cycle (entry outputs registered); no bypass.
//  - Reset mid-operation: held op dropped immediately, no clear pulse emitted.
// CONFIGURATION
//  ISQ_SELECT_AGE_EN defined: oldest-first. Age matrix older[i][j] (i older than j). On alloc_vec[i]:
//    row i<=0, column i<=1 for all j!=i (i younger than everyone). Multiple allocs same cycle:
//    lower index is older. Winner = ready i with no ready j where older[j][i].
//  ISQ_SELECT_AGE_EN undefined: fixed priority, lowest ready index wins; no age state, alloc_vec ignored.
// STRUCTURE
//  - isq_pkg: DEPTH/width constants, issue_slot_t typedef, onehot-to-index function.
//  - Sub-module isq_age_matrix (DEPTH): alloc_vec, req_vec in; grant one-hot out; only under the macro.
//  - Top: output register, handshake, clear_vec generation, priority fallback.
// TESTING
//  1. Reset, ready_vec=0 -> issue_valid=0, clear_vec=0 for 10 cycles.
//  2. ready_vec=8'b0000_0100, issue_ready=1 -> clear_vec=8'b0000_0100 same cycle; next cycle
//     issue_valid=1, issue_slot=2, issue_data=entry_data[2].
//  3. ready_vec=8'hFF, issue_ready=0 after first issue -> exactly one clear pulse; outputs stable
//     until issue_ready=1, then next clear fires that cycle.
//  4. Age mode: alloc 5, then 1, then 3 in separate cycles; ready all three -> issue order 5,1,3.
//     Fixed mode: order 1,3,5. Same-cycle alloc of 6 and 2 -> age mode issues 2 then 6.
//  5. issue_valid=1 held, flush=1 with ready_vec=8'h01 -> clear_vec=0; next cycle issue_valid=0.
//  6. Assert reset_n=0 mid-stream with issue_valid=1 -> issue_valid=0 asynchronously, age state 0.

Source files
------------

// File: rtl/isq_pkg.sv
// Shared constants, types and helpers for the issue-queue select logic.
// Payload/index widths come from ISQ_DATA_WIDTH / ISQ_INDEX_WIDTH when the
// build defines them; otherwise the defaults below apply.
`ifndef ISQ_DATA_WIDTH
`define ISQ_DATA_WIDTH 32
`endif
`ifndef ISQ_INDEX_WIDTH
`define ISQ_INDEX_WIDTH 6
`endif

package isq_pkg;

    localparam int ISQ_DEPTH       = 8;
    localparam int ISQ_DATA_WIDTH  = `ISQ_DATA_WIDTH;
    localparam int ISQ_INDEX_WIDTH = `ISQ_INDEX_WIDTH;
    localparam int ISQ_SLOT_WIDTH  = $clog2(ISQ_DEPTH);

    typedef logic [ISQ_SLOT_WIDTH-1:0] issue_slot_t;

    // Entry number of the set bit of a one-hot vector (0 when the vector is empty).
    function automatic issue_slot_t onehot_to_index(input logic [ISQ_DEPTH-1:0] oh);
        issue_slot_t idx;
        idx = '0;
        for (int i = 0; i < ISQ_DEPTH; i++) begin
            if (oh[i]) idx = issue_slot_t'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/isq_age_matrix.sv
// Age matrix for oldest-first selection. r_older[i][j] means entry i is older
// than entry j. A newly allocated entry becomes younger than every other entry;
// when several entries are allocated in the same cycle the lower index is older.
// Only instantiated when ISQ_SELECT_AGE_EN is defined.
module isq_age_matrix #(
    parameter int DEPTH = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [DEPTH-1:0] alloc_vec,
    input  logic [DEPTH-1:0] req_vec,
    output logic [DEPTH-1:0] grant_vec
);

    logic [DEPTH-1:0] r_older [DEPTH];
    logic [DEPTH-1:0] w_blocked;

    // Update age relations on allocation; diagonal stays 0.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) r_older[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                for (int j = 0; j < DEPTH; j++) begin
                    if (i != j) begin
                        if (alloc_vec[i] && alloc_vec[j]) r_older[i][j] <= (i < j);
                        else if (alloc_vec[i])            r_older[i][j] <= 1'b0;
                        else if (alloc_vec[j])            r_older[i][j] <= 1'b1;
                    end
                end
            end
        end
    end

    // A requester is blocked when some other requester is older than it.
    always_comb begin
        w_blocked = '0;
        for (int i = 0; i < DEPTH; i++) begin
            for (int j = 0; j < DEPTH; j++) begin
                if (j != i) w_blocked[i] = w_blocked[i] | (req_vec[j] & r_older[j][i]);
            end
        end
    end

    // Entries with no age history tie; the top breaks ties by lowest index.
    assign grant_vec = req_vec & ~w_blocked;

endmodule

// File: rtl/isq_issue_select.sv
// Issue select: picks one ready ISQ entry per cycle, pulses its clear_entry
// and loads it into a 1-deep output register toward the function unit.
// ISQ_SELECT_AGE_EN defined: oldest-first via isq_age_matrix.
// ISQ_SELECT_AGE_EN undefined: lowest ready index wins, alloc_vec ignored.
//
// Handshake: issue_valid/issue_data/issue_index/issue_slot are held stable
// while issue_valid && !issue_ready; the op transfers on a clock edge where
// issue_valid && issue_ready. A new entry is selected (and cleared) only on a
// cycle where the register is empty or draining, flush is low and reset is
// deasserted.
module isq_issue_select
    import isq_pkg::*;
#(
    parameter int DEPTH       = ISQ_DEPTH,
    parameter int DATA_WIDTH  = ISQ_DATA_WIDTH,
    parameter int INDEX_WIDTH = ISQ_INDEX_WIDTH
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         flush,
    input  logic [DEPTH-1:0]             alloc_vec,
    input  logic [DEPTH-1:0]             ready_vec,
    input  logic [DEPTH*DATA_WIDTH-1:0]  entry_data,
    input  logic [DEPTH*INDEX_WIDTH-1:0] entry_index,
    output logic [DEPTH-1:0]             clear_vec,
    output logic                         issue_valid,
    input  logic                         issue_ready,
    output logic [DATA_WIDTH-1:0]        issue_data,
    output logic [INDEX_WIDTH-1:0]       issue_index,
    output logic [$clog2(DEPTH)-1:0]     issue_slot
);

    logic                     r_issue_valid;
    logic [DATA_WIDTH-1:0]    r_issue_data;
    logic [INDEX_WIDTH-1:0]   r_issue_index;
    logic [$clog2(DEPTH)-1:0] r_issue_slot;

    logic                     w_can_load;
    logic                     w_select;
    logic [DEPTH-1:0]         w_cand;
    logic [DEPTH-1:0]         w_winner_oh;
    logic [$clog2(DEPTH)-1:0] w_slot;
    logic [DATA_WIDTH-1:0]    w_sel_data;
    logic [INDEX_WIDTH-1:0]   w_sel_index;

`ifdef ISQ_SELECT_AGE_EN
    isq_age_matrix #(.DEPTH(DEPTH)) u_age (
        .clock     (clock),
        .reset_n   (reset_n),
        .alloc_vec (alloc_vec),
        .req_vec   (ready_vec),
        .grant_vec (w_cand)
    );
`else
    logic w_unused_alloc;
    assign w_unused_alloc = ^alloc_vec;
    assign w_cand         = ready_vec;
`endif

    assign w_can_load  = !r_issue_valid || issue_ready;
    assign w_select    = reset_n && w_can_load && !flush;
    // Lowest set candidate bit: priority fallback and age-tie breaker.
    assign w_winner_oh = w_cand & (~w_cand + DEPTH'(1));
    assign clear_vec   = w_select ? w_winner_oh : '0;
    assign w_slot      = onehot_to_index(w_winner_oh);

    // Mux the winning entry's payload and index.
    always_comb begin
        w_sel_data  = '0;
        w_sel_index = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_winner_oh[i]) begin
                w_sel_data  = entry_data[i*DATA_WIDTH +: DATA_WIDTH];
                w_sel_index = entry_index[i*INDEX_WIDTH +: INDEX_WIDTH];
            end
        end
    end

    // Output register: load the winner, drain when empty, hold under backpressure.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_issue_valid <= 1'b0;
            r_issue_data  <= '0;
            r_issue_index <= '0;
            r_issue_slot  <= '0;
        end else if (flush) begin
            r_issue_valid <= 1'b0;
        end else if (w_can_load) begin
            if (|ready_vec) begin
                r_issue_valid <= 1'b1;
                r_issue_data  <= w_sel_data;
                r_issue_index <= w_sel_index;
                r_issue_slot  <= w_slot;
            end else begin
                r_issue_valid <= 1'b0;
            end
        end
    end

    assign issue_valid = r_issue_valid;
    assign issue_data  = r_issue_data;
    assign issue_index = r_issue_index;
    assign issue_slot  = r_issue_slot;

endmodule

// File: tb/tb_isq_issue_select.sv
// Directed bench for isq_issue_select; expected issued ops are queued when
// their clear pulse is expected and compared when the FU accepts them.
module tb_isq_issue_select;
    import isq_pkg::*;

    localparam int D  = ISQ_DEPTH;
    localparam int DW = ISQ_DATA_WIDTH;
    localparam int IW = ISQ_INDEX_WIDTH;
    localparam int SW = ISQ_SLOT_WIDTH;
    localparam int EW = SW + DW + IW;
`ifdef ISQ_SELECT_AGE_EN
    localparam bit AGE = 1'b1;
`else
    localparam bit AGE = 1'b0;
`endif

    logic              clock;
    logic              reset_n;
    logic              flush;
    logic [D-1:0]      alloc_vec;
    logic [D-1:0]      ready_vec;
    logic [D*DW-1:0]   entry_data;
    logic [D*IW-1:0]   entry_index;
    logic [D-1:0]      clear_vec;
    logic              issue_valid;
    logic              issue_ready;
    logic [DW-1:0]     issue_data;
    logic [IW-1:0]     issue_index;
    logic [SW-1:0]     issue_slot;

    logic [DW-1:0]     ent_d [D];
    logic [IW-1:0]     ent_i [D];
    logic [EW-1:0]     exp_q [$];
    int                checks;
    int                failures;

    isq_issue_select dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .flush       (flush),
        .alloc_vec   (alloc_vec),
        .ready_vec   (ready_vec),
        .entry_data  (entry_data),
        .entry_index (entry_index),
        .clear_vec   (clear_vec),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .issue_data  (issue_data),
        .issue_index (issue_index),
        .issue_slot  (issue_slot)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always_comb begin
        for (int i = 0; i < D; i++) begin
            entry_data[i*DW +: DW]  = ent_d[i];
            entry_index[i*IW +: IW] = ent_i[i];
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int slot_of(input logic [D-1:0] oh);
        int s;
        s = 0;
        for (int i = 0; i < D; i++) if (oh[i]) s = i;
        return s;
    endfunction

    // One cycle: drive at the falling edge, check comb clear and any accepted op,
    // queue the op expected from this cycle's clear, then run through the rising edge.
    task automatic drive_step(input logic [D-1:0] rdy, input logic irdy, input logic fl,
                              input logic [D-1:0] alloc, input logic [D-1:0] exp_clear,
                              input string tag);
        logic [EW-1:0] item;
        int s;
        ready_vec   = rdy;
        issue_ready = irdy;
        flush       = fl;
        alloc_vec   = alloc;
        #1;
        if (issue_valid && (irdy || fl)) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $error("FAIL %s_unexpected_issue observed=slot%0d expected=none", tag, issue_slot);
            end else begin
                item = exp_q.pop_front();
                if (!fl) check({tag, "_issue"}, 64'({issue_slot, issue_data, issue_index}), 64'(item));
            end
        end
        check({tag, "_clear"}, 64'(clear_vec), 64'(exp_clear));
        if (exp_clear != '0) begin
            s = slot_of(exp_clear);
            exp_q.push_back({SW'(s), ent_d[s], ent_i[s]});
        end
        @(posedge clock);
        @(negedge clock);
    endtask

    initial begin
        int ord [3];
        logic [D-1:0] rem;
        logic [D-1:0] e;
        checks      = 0;
        failures    = 0;
        reset_n     = 1'b0;
        flush       = 1'b0;
        alloc_vec   = '0;
        ready_vec   = '0;
        issue_ready = 1'b0;
        for (int i = 0; i < D; i++) begin
            ent_d[i] = DW'($urandom);
            ent_i[i] = IW'($urandom_range(0, (1 << IW) - 1));
        end
        @(negedge clock);
        @(negedge clock);
        check("rst_valid", 64'(issue_valid), 64'(0));
        check("rst_data",  64'(issue_data),  64'(0));
        check("rst_index", 64'(issue_index), 64'(0));
        check("rst_slot",  64'(issue_slot),  64'(0));
        check("rst_clear", 64'(clear_vec),   64'(0));
        reset_n = 1'b1;

        // Idle after reset.
        repeat (10) begin
            drive_step('0, 1'b1, 1'b0, '0, '0, "t1");
            check("t1_valid", 64'(issue_valid), 64'(0));
        end

        // Single ready entry: clear same cycle, issue next cycle.
        drive_step(8'h04, 1'b1, 1'b0, '0, 8'h04, "t2");
        check("t2_valid", 64'(issue_valid), 64'(1));
        check("t2_slot",  64'(issue_slot),  64'(2));
        check("t2_data",  64'(issue_data),  64'(ent_d[2]));
        drive_step('0, 1'b1, 1'b0, '0, '0, "t2_drain");
        check("t2_empty", 64'(issue_valid), 64'(0));

        // Backpressure then back-to-back drain of all eight entries.
        drive_step(8'hFF, 1'b1, 1'b0, '0, 8'h01, "t3_first");
        repeat (3) begin
            drive_step(8'hFE, 1'b0, 1'b0, '0, '0, "t3_hold");
            check("t3_hold_valid", 64'(issue_valid), 64'(1));
            check("t3_hold_slot",  64'(issue_slot),  64'(0));
            check("t3_hold_data",  64'(issue_data),  64'(ent_d[0]));
        end
        for (int i = 1; i < D; i++) begin
            drive_step(8'hFF << i, 1'b1, 1'b0, '0, 8'h01 << i, "t3_b2b");
            check("t3_b2b_valid", 64'(issue_valid), 64'(1));
        end
        drive_step('0, 1'b1, 1'b0, '0, '0, "t3_drain");
        check("t3_empty", 64'(issue_valid), 64'(0));

        // Allocation order 5, 1, 3.
        drive_step('0, 1'b1, 1'b0, 8'h20, '0, "t4_alloc5");
        drive_step('0, 1'b1, 1'b0, 8'h02, '0, "t4_alloc1");
        drive_step('0, 1'b1, 1'b0, 8'h08, '0, "t4_alloc3");
        if (AGE) ord = '{5, 1, 3};
        else     ord = '{1, 3, 5};
        rem = 8'h2A;
        for (int k = 0; k < 3; k++) begin
            e = 8'h01 << ord[k];
            drive_step(rem, 1'b1, 1'b0, '0, e, "t4_order");
            rem = rem & ~e;
        end
        drive_step('0, 1'b1, 1'b0, '0, '0, "t4_drain");
        // Same-cycle allocation of 6 and 2: lower index is older.
        drive_step('0, 1'b1, 1'b0, 8'h44, '0, "t4_alloc62");
        drive_step(8'h44, 1'b1, 1'b0, '0, 8'h04, "t4_same2");
        drive_step(8'h40, 1'b1, 1'b0, '0, 8'h40, "t4_same6");
        drive_step('0, 1'b1, 1'b0, '0, '0, "t4_drain2");
        check("t4_empty", 64'(issue_valid), 64'(0));

        // Flush with a held op.
        drive_step(8'h01, 1'b1, 1'b0, '0, 8'h01, "t5_load");
        check("t5_valid", 64'(issue_valid), 64'(1));
        drive_step(8'h01, 1'b0, 1'b1, '0, '0, "t5_flush");
        check("t5_killed", 64'(issue_valid), 64'(0));
        drive_step('0, 1'b1, 1'b0, '0, '0, "t5_idle");

        // Asynchronous reset mid-stream, after re-establishing age history 5,1,3.
        drive_step('0, 1'b1, 1'b0, 8'h20, '0, "t6_alloc5");
        drive_step('0, 1'b1, 1'b0, 8'h02, '0, "t6_alloc1");
        drive_step('0, 1'b1, 1'b0, 8'h08, '0, "t6_alloc3");
        drive_step(8'h02, 1'b1, 1'b0, '0, 8'h02, "t6_load");
        check("t6_valid_pre", 64'(issue_valid), 64'(1));
        #2;
        reset_n = 1'b0;
        #1;
        check("t6_async_valid", 64'(issue_valid), 64'(0));
        check("t6_async_data",  64'(issue_data),  64'(0));
        ready_vec = 8'h02;
        #1;
        check("t6_no_clear", 64'(clear_vec), 64'(0));
        exp_q.delete();
        @(negedge clock);
        reset_n = 1'b1;
        // Age history cleared: ready entries tie, lowest index first.
        drive_step(8'h2A, 1'b1, 1'b0, '0, 8'h02, "t6_after1");
        drive_step(8'h28, 1'b1, 1'b0, '0, 8'h08, "t6_after3");
        drive_step(8'h20, 1'b1, 1'b0, '0, 8'h20, "t6_after5");
        drive_step('0, 1'b1, 1'b0, '0, '0, "t6_drain");
        check("t6_empty", 64'(issue_valid), 64'(0));
        check("q_empty", 64'(exp_q.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
